// File: rtl/yzh_led_pkg.sv
// -----------------------------------------------------------------------------
// yzh_led_pkg
// Shared definitions for the AXI4-Lite LED PWM slave: register offsets,
// AXI response code, CTRL bit positions and the write/read FSM state types.
// No ports (package).
// -----------------------------------------------------------------------------
package yzh_led_pkg;

   // Byte offsets of the four registers; bits [3:2] form the register index.
   localparam logic [3:0] REG_CTRL    = 4'h0;
   localparam logic [3:0] REG_DUTY    = 4'h4;
   localparam logic [3:0] REG_PERIOD  = 4'h8;
   localparam logic [3:0] REG_PATTERN = 4'hC;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   localparam int CTRL_ENABLE_BIT = 0;
   localparam int CTRL_BLINK_BIT  = 1;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_HAVE_AW,
      WR_HAVE_W,
      WR_RESP
   } wr_state_e;

   typedef enum logic {
      RD_IDLE,
      RD_RESP
   } rd_state_e;

endpackage

// File: rtl/led_pwm_gen.sv
// -----------------------------------------------------------------------------
// led_pwm_gen
// PWM dimmer and optional blinker for the LED bank. An 8-bit free-running
// counter sets the PWM duty; a 32-bit prescaler toggles a blink phase every
// PERIOD cycles. The LED output is registered.
// Build option: YZH_LED_BLINK_EN -- when undefined no prescaler is built and
// the blink phase is permanently 1 (blink_mode/period/period_wr ignored).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : CTRL enable bit
//   blink_mode    : CTRL blink bit
//   duty[7:0]     : PWM duty (0x00 off, 0xFF fully on)
//   period[31:0]  : blink half-period in cycles (0 holds phase on)
//   period_wr     : one-cycle pulse when PERIOD is written
//   pattern       : LED mask
//   led           : registered LED drive, active-high
// -----------------------------------------------------------------------------
module led_pwm_gen #(
   parameter int LED_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             blink_mode,
   input  logic [7:0]       duty,
   input  logic [31:0]      period,
   input  logic             period_wr,
   input  logic [LED_W-1:0] pattern,
   output logic [LED_W-1:0] led
);

   logic [7:0]       cnt_q, cnt_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             pwm_on;
   logic             phase;
   logic             gate;

   // 0xFF is special-cased so that full duty has no off slot at cnt==0xFF.
   assign pwm_on = (cnt_q < duty) | (duty == 8'hFF);

`ifdef YZH_LED_BLINK_EN
   logic [31:0] presc_q, presc_d;
   logic        phase_q, phase_d;

   always_comb begin
      presc_d = presc_q + 32'd1;
      phase_d = phase_q;
      if (period_wr || (period == 32'd0)) begin
         presc_d = '0;
         phase_d = 1'b1;
      end else if (presc_q >= period - 32'd1) begin
         // >= rather than == so a stale count above a shrunk period still wraps
         presc_d = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         phase_q <= 1'b1;
      end else begin
         presc_q <= presc_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;
   assign gate  = pwm_on & enable & (phase | ~blink_mode);
`else
   logic unused_blink;
   assign unused_blink = ^{blink_mode, period, period_wr};
   assign phase        = 1'b1;
   assign gate         = pwm_on & enable & phase;
`endif

   always_comb begin
      cnt_d = cnt_q + 8'd1;
      led_d = pattern & {LED_W{gate}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         led_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         led_q <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: rtl/axi_lite_led_pwm_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_led_pwm_slave
// AXI4-Lite slave with four 32-bit R/W registers (CTRL 0x0, DUTY 0x4,
// PERIOD 0x8, PATTERN 0xC) driving a PWM-dimmed, optionally blinking LED bank
// through led_pwm_gen. One outstanding transaction per direction.
// Build option: YZH_LED_BLINK_EN (consumed by led_pwm_gen) enables blinking.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET          : clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*                   : write address / data / response
//   S_AXI_AR*/R*                      : read address / data
//   led[C_LED_WIDTH-1:0]              : LED drive, active-high
// -----------------------------------------------------------------------------
module axi_lite_led_pwm_slave
   import yzh_led_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int C_LED_WIDTH        = 8
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_LED_WIDTH-1:0]          led
);

   localparam int         DW          = C_S_AXI_DATA_WIDTH;
   localparam int         STRB_W      = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [1:0] IDX_CTRL    = REG_CTRL[3:2];
   localparam logic [1:0] IDX_DUTY    = REG_DUTY[3:2];
   localparam logic [1:0] IDX_PERIOD  = REG_PERIOD[3:2];
   localparam logic [1:0] IDX_PATTERN = REG_PATTERN[3:2];

   wr_state_e         wr_state_q, wr_state_d;
   rd_state_e         rd_state_q, rd_state_d;
   logic [1:0]        waddr_q, waddr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic [DW-1:0]     regs_q [4];
   logic [DW-1:0]     regs_d [4];
   logic [DW-1:0]     rdata_q, rdata_d;

   logic              aw_ready, w_ready, ar_ready;
   logic              aw_hs, w_hs, ar_hs;
   logic              commit;
   logic [1:0]        commit_idx;
   logic [DW-1:0]     commit_data;
   logic [STRB_W-1:0] commit_strb;
   logic              period_wr;

   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   // Readies are forced low while reset is held so nothing is accepted then.
   always_comb begin
      aw_ready = ~S_AXI_ARESET & ((wr_state_q == WR_IDLE) | (wr_state_q == WR_HAVE_W));
      w_ready  = ~S_AXI_ARESET & ((wr_state_q == WR_IDLE) | (wr_state_q == WR_HAVE_AW));
      ar_ready = ~S_AXI_ARESET & (rd_state_q == RD_IDLE);
   end

   assign aw_hs = S_AXI_AWVALID & aw_ready;
   assign w_hs  = S_AXI_WVALID & w_ready;
   assign ar_hs = S_AXI_ARVALID & ar_ready;

   // Write FSM: the half that arrives first is parked; the commit uses the
   // parked half plus whatever is on the bus for the other one.
   always_comb begin
      wr_state_d  = wr_state_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      commit      = 1'b0;
      commit_idx  = (wr_state_q == WR_HAVE_AW) ? waddr_q : S_AXI_AWADDR[3:2];
      commit_data = (wr_state_q == WR_HAVE_W) ? wdata_q : S_AXI_WDATA;
      commit_strb = (wr_state_q == WR_HAVE_W) ? wstrb_q : S_AXI_WSTRB;
      case (wr_state_q)
         WR_IDLE: begin
            if (aw_hs && w_hs) begin
               commit     = 1'b1;
               wr_state_d = WR_RESP;
            end else if (aw_hs) begin
               waddr_d    = S_AXI_AWADDR[3:2];
               wr_state_d = WR_HAVE_AW;
            end else if (w_hs) begin
               wdata_d    = S_AXI_WDATA;
               wstrb_d    = S_AXI_WSTRB;
               wr_state_d = WR_HAVE_W;
            end
         end
         WR_HAVE_AW: begin
            if (w_hs) begin
               commit     = 1'b1;
               wr_state_d = WR_RESP;
            end
         end
         WR_HAVE_W: begin
            if (aw_hs) begin
               commit     = 1'b1;
               wr_state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            if (S_AXI_BREADY) begin
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (commit) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (commit_strb[b]) begin
               regs_d[commit_idx][8*b +: 8] = commit_data[8*b +: 8];
            end
         end
      end
   end

   assign period_wr = commit & (commit_idx == IDX_PERIOD);

   // Read FSM: RDATA samples the pre-write register value, so a same-cycle
   // write to the same register is not visible to this read.
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (ar_hs) begin
               rdata_d    = regs_q[S_AXI_ARADDR[3:2]];
               rd_state_d = RD_RESP;
            end
         end
         RD_RESP: begin
            if (S_AXI_RREADY) begin
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         wr_state_q <= WR_IDLE;
         rd_state_q <= RD_IDLE;
         waddr_q    <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rdata_q    <= '0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         rdata_q    <= rdata_d;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign S_AXI_AWREADY = aw_ready;
   assign S_AXI_WREADY  = w_ready;
   assign S_AXI_ARREADY = ar_ready;
   assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_RVALID  = (rd_state_q == RD_RESP);
   assign S_AXI_RRESP   = RESP_OKAY;
   assign S_AXI_RDATA   = rdata_q;

   led_pwm_gen #(
      .LED_W (C_LED_WIDTH)
   ) u_led_pwm_gen (
      .clk        (S_AXI_ACLK),
      .rst        (S_AXI_ARESET),
      .enable     (regs_q[IDX_CTRL][CTRL_ENABLE_BIT]),
      .blink_mode (regs_q[IDX_CTRL][CTRL_BLINK_BIT]),
      .duty       (regs_q[IDX_DUTY][7:0]),
      .period     (regs_q[IDX_PERIOD]),
      .period_wr  (period_wr),
      .pattern    (regs_q[IDX_PATTERN][C_LED_WIDTH-1:0]),
      .led        (led)
   );

endmodule
